// File: rtl/mgc_fifo_pkg.sv
// mgc_fifo_pkg: shared occupancy-state type and pointer wrap helper for the output FIFO.
package mgc_fifo_pkg;
    typedef enum logic [1:0] {FIFO_EMPTY, FIFO_PARTIAL, FIFO_FULL} fifo_state_e;
    // Depth need not be a power of two, so wrap is an explicit compare against the last slot.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned fifo_sz);
        return (ptr == fifo_sz - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/mgc_out_fifo_sync_if.sv
// mgc_out_fifo_sync_if: design push side and port pop side of the output FIFO.
// size/ovf exist only when MGC_FIFO_STATUS_EN is defined.
interface mgc_out_fifo_sync_if #(
    parameter int width   = 8,
    parameter int ph_log2 = 3
);
    logic             ld;
    logic             vd;
    logic [width-1:0] d;
    logic             lz;
    logic             vz;
    logic [width-1:0] z;
`ifdef MGC_FIFO_STATUS_EN
    logic [ph_log2:0] size;
    logic             ovf;
    modport slave  (input ld, d, vz, output vd, lz, z, size, ovf);
    modport master (output ld, d, vz, input vd, lz, z, size, ovf);
`else
    modport slave  (input ld, d, vz, output vd, lz, z);
    modport master (output ld, d, vz, input vd, lz, z);
`endif
endinterface

// File: rtl/mgc_fifo_ram.sv
// mgc_fifo_ram: fifo_sz x width storage, one synchronous write port, one asynchronous read port.
module mgc_fifo_ram #(
    parameter int width   = 8,
    parameter int fifo_sz = 8,
    parameter int aw      = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    wa,
    input  logic [width-1:0] wd,
    input  logic [aw-1:0]    ra,
    output logic [width-1:0] rd
);
    logic [width-1:0] mem [fifo_sz];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign rd = mem[ra];
endmodule

// File: rtl/mgc_out_fifo_sync.sv
// mgc_out_fifo_sync: synchronous output FIFO with valid/accept handshake toward the port side.
// Define MGC_FIFO_STATUS_EN to add the size and sticky ovf status outputs.
module mgc_out_fifo_sync
    import mgc_fifo_pkg::*;
#(
    parameter int rscid   = 0,
    parameter int width   = 8,
    parameter int fifo_sz = 8,
    parameter int ph_log2 = 3
) (
    input logic                clk,
    input logic                srst,
    input logic                en,
    mgc_out_fifo_sync_if.slave f
);
    localparam int PW = (ph_log2 > 0) ? ph_log2 : 1;
    localparam int CW = ph_log2 + 1;

    if (fifo_sz < 1 || rscid < 0) begin : g_bad_cfg
        $error("mgc_out_fifo_sync: invalid fifo_sz or rscid");
    end

    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;
    logic [width-1:0] rd;
    fifo_state_e      st;

    // Flags decode from registered occupancy only; no vz->vd or ld->lz path.
    assign f.vd = cnt_q != CW'(fifo_sz);
    assign f.lz = cnt_q != '0;
    assign f.z  = f.lz ? rd : '0;
    assign push = en && f.ld && f.vd;
    assign pop  = en && f.lz && f.vz;
    assign st   = !f.lz ? FIFO_EMPTY : !f.vd ? FIFO_FULL : FIFO_PARTIAL;

    always_comb begin
        wp_d  = push ? PW'(next_ptr(32'(wp_q), fifo_sz)) : wp_q;
        rp_d  = pop ? PW'(next_ptr(32'(rp_q), fifo_sz)) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    mgc_fifo_ram #(.width(width), .fifo_sz(fifo_sz), .aw(PW)) u_ram (
        .clk(clk),
        .we (push),
        .wa (wp_q),
        .wd (f.d),
        .ra (rp_q),
        .rd (rd)
    );

`ifdef MGC_FIFO_STATUS_EN
    logic ovf_q, ovf_d;
    assign ovf_d  = ovf_q | (en && f.ld && !f.vd);
    assign f.size = cnt_q;
    assign f.ovf  = ovf_q;
    always_ff @(posedge clk) begin
        if (srst) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
`endif

    assert property (@(posedge clk) disable iff (srst) (st == FIFO_EMPTY) |-> (f.z == '0));
    assert property (@(posedge clk) disable iff (srst) cnt_q <= CW'(fifo_sz));
endmodule

// File: doc/mgc_out_fifo_sync.md
# mgc_out_fifo_sync

Synchronous output FIFO that buffers design writes toward an output or inout port resource and presents them to the port side with a valid/accept handshake. It is the buffering stage that sits directly upstream of the inout FIFO wrapper: the wrapper consumes `lz`/`z`, gates them onto the tri-state pad, and returns `vz`. Depth is configurable. Flags are derived only from registered state.

## Interface
Parameters:
- `rscid`, 0, resource ID; carried through for tooling, no functional effect
- `width`, 8, data width in bits
- `fifo_sz`, 8, depth in entries; must be ≥ 1; need not be a power of two
- `ph_log2`, 3, ceil(log2(`fifo_sz`)); pointer width is `ph_log2`, count width is `ph_log2+1`

Ports:
- `clk`  in  1  clock; rising edge
- `srst`  in  1  reset; synchronous, active-high
- `en`  in  1  clock enable, active-high; when low, no state changes
- `ld`  in  1  design push request
- `vd`  out  1  design side may push (FIFO not full)
- `d`  in  `width`  push data
- `lz`  out  1  port side data valid (FIFO not empty)
- `vz`  in  1  port side accepts the head entry this cycle
- `z`  out  `width`  head entry data
- `size`  out  `ph_log2+1`  occupancy; present only with `MGC_FIFO_STATUS_EN`
- `ovf`  out  1  sticky overflow flag; present only with `MGC_FIFO_STATUS_EN`

## Operation
- State: storage array of `fifo_sz` × `width` bits, write pointer `wp`, read pointer `rp`, occupancy `cnt`.
- Push: accepted when `en && ld && vd`. Write `d` to `mem[wp]`, then advance `wp`.
- Pop: occurs when `en && lz && vz`. Advance `rp`.
- Pointer wrap: a pointer at `fifo_sz-1` wraps to 0. This is an explicit compare, not modulo 2^`ph_log2`.
- Occupancy: `cnt` increments on a push-only cycle, decrements on a pop-only cycle, and is unchanged on push+pop.
- Flags: `vd = (cnt != fifo_sz)` and `lz = (cnt != 0)`. Both decode from registered `cnt`. There is no combinational path from `vz` to `vd` or from `ld` to `lz`.
- Data out: `z = lz ? mem[rp] : 0`. Never X while empty.
- Derived states:
  - EMPTY (`cnt == 0`)
  - PARTIAL
  - FULL (`cnt == fifo_sz`)
  - Transitions follow `cnt` only. With `fifo_sz == 1`, the FIFO moves directly EMPTY↔FULL.
- Boundary conditions:
  - Full with `ld=1`: push refused and `mem` unchanged, even if a pop happens the same cycle. `vd` rises the next cycle.
  - Empty with `vz=1`: no pop; `rp` unchanged.
  - Push and pop in the same cycle while PARTIAL: both occur; `cnt` held.
  - `en=0`: pointers, `cnt`, `mem` and `ovf` all hold. Flags and `z` stay consistent with the held state.
- Reset applies when `srst=1` at a clock edge, regardless of `en`, including mid-stream:
  - `wp=rp=cnt=0`, so `vd=1`, `lz=0`, `z=0`
  - `size=0`, `ovf=0`
  - Storage contents are not cleared; all in-flight entries are discarded.

## Timing
- Write-to-read latency: 1 cycle. Data pushed at edge N appears on `z` with `lz=1` after edge N.
- Pop-to-space latency: 1 cycle. After a pop from FULL, `vd=1` after that edge.
- Throughput: 1 push and 1 pop per cycle sustained when PARTIAL.
- Full cycle-level behaviour: a stream at 1 entry/cycle with `vz` held high sees `lz` toggle only at the start and end of the stream.

## Configuration
- `MGC_FIFO_STATUS_EN` defined:
  - Adds the `size` and `ovf` ports.
  - `size = cnt`.
  - `ovf` is set on any edge with `en && ld && !vd`, and cleared only by `srst`.
- Not defined:
  - Those ports and their logic are absent.
  - Refused pushes are silently dropped.
  - Core behaviour is identical in both builds.

## Structure
- Package `mgc_fifo_pkg` holds:
  - occupancy-state enum (`FIFO_EMPTY`, `FIFO_PARTIAL`, `FIFO_FULL`), used for assertions and debug
  - helper function `next_ptr(ptr, fifo_sz)` for wrap
- One sub-module, `mgc_fifo_ram`: `fifo_sz` × `width` storage with 1 synchronous write port and 1 asynchronous read port, no reset.
- Pointer, count and flag logic stays in the top module.

## Test plan
- Reset then idle: `srst=1` for 2 cycles, then 0 → `vd=1`, `lz=0`, `z=0`, `size=0`, `ovf=0`.
- Fill and drain, `fifo_sz=8`, `width=8`: push 0x01..0x08 with `vz=0` → `vd=0` after 8th push, `size=8`. Then `vz=1` → `z` yields 0x01..0x08 in order on consecutive cycles; `lz=0` after the last.
- Overflow with status enabled: while full, `ld=1` with `d=0xAA` → no write, `ovf=1` and stays 1. After draining, 0xAA never appears on `z`.
- Simultaneous push/pop at `cnt=3`: `ld=vz=1` for 20 cycles with incrementing data → `cnt` stays 3, output is the input delayed by 3 entries, `rp` and `wp` wrap correctly.
- Non-power-of-two wrap, `fifo_sz=5`, `ph_log2=3`: 13 pushes and pops interleaved → order preserved, no entry duplicated or lost.
- Reset and enable mid-operation:
  - `srst=1` at `cnt=4` → next cycle `lz=0`, `vd=1`, `size=0`; a new push 0x55 is the first value read.
  - `en=0` for 3 cycles with `ld=vz=1` → `cnt`, `z` and flags unchanged.
